// File: rtl/skein_pkg.sv
// Shared types and helpers for the Skein-1024 / Threefish-1024 block sequencer.
//
// Contents:
//   C240        - Threefish key-schedule parity constant
//   word_t      - one 64-bit Threefish word
//   block_t     - one 1024-bit block (16 words, word i at bits [64i+63:64i])
//   state_t     - sequencer FSM states
//   subkey_cnt  - number of subkeys used for a given iteration count
//   add_words   - wordwise mod-2^64 addition of two blocks
//   inc_mod3 / inc_mod17 - wrap-counter increments used for subkey indexing
package skein_pkg;

    localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

    typedef logic [63:0]   word_t;
    typedef logic [1023:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Subkeys K_0 .. K_{2*num_iter}.
    function automatic int subkey_cnt(input int num_iter);
        return 2 * num_iter + 1;
    endfunction

    // Sixteen independent 64-bit adds; carries never cross word boundaries.
    function automatic block_t add_words(input block_t a, input block_t b);
        block_t r;
        for (int i = 0; i < 16; i++) begin
            r[64*i +: 64] = a[64*i +: 64] + b[64*i +: 64];
        end
        return r;
    endfunction

    function automatic logic [1:0] inc_mod3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [4:0] inc_mod17(input logic [4:0] x);
        return (x == 5'd16) ? 5'd0 : x + 5'd1;
    endfunction

endpackage

// File: rtl/skein1024_subkey.sv
// Combinational Threefish-1024 subkey generator.
//
// Produces K_s from the extended key and tweak:
//   word i  = k[(s+i) mod 17]
//   word 13 += t[s mod 3]
//   word 14 += t[(s+1) mod 3]
//   word 15 += s
//
// Ports:
//   k       in   17 x 64  extended key k0..k16 (k16 already holds the parity word)
//   t       in   3 x 64   extended tweak t0..t2 (t2 = t0 ^ t1)
//   s       in   SW       subkey index
//   s_mod3  in   2        s mod 3, supplied by the caller's wrap counter
//   s_mod17 in   5        s mod 17, supplied by the caller's wrap counter
//   ks      out  1024     subkey K_s
module skein1024_subkey
    import skein_pkg::*;
#(
    parameter int SW = 5
) (
    input  word_t          k [17],
    input  word_t          t [3],
    input  logic [SW-1:0]  s,
    input  logic [1:0]     s_mod3,
    input  logic [4:0]     s_mod17,
    output block_t         ks
);

    // s_mod17 + i is at most 31, so a single conditional subtract wraps it.
    function automatic logic [4:0] wrap17(input logic [4:0] x);
        return (x >= 5'd17) ? x - 5'd17 : x;
    endfunction

    always_comb begin
        ks = '0;
        for (int i = 0; i < 16; i++) begin
            ks[64*i +: 64] = k[wrap17(s_mod17 + 5'(i))];
        end
        ks[64*13 +: 64] = ks[64*13 +: 64] + t[s_mod3];
        ks[64*14 +: 64] = ks[64*14 +: 64] + t[inc_mod3(s_mod3)];
        ks[64*15 +: 64] = ks[64*15 +: 64] + 64'(s);
    end

endmodule

// File: rtl/skein_threefish_sequencer.sv
// Threefish-1024 block sequencer for the Skein-1024 UBI core.
//
// Walks one block through an external shared round datapath: each iteration
// injects K_s, runs the even round group, injects K_{s+1}, runs the odd
// round group. After NUM_ITER iterations the final subkey K_{2*NUM_ITER} is
// added and the ciphertext is held on out_data until the consumer takes it.
// Only one block is in flight at a time.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Upstream: in_ready is high only in IDLE.
// Downstream: out_valid/out_data hold until out_ready is sampled high;
// no new block is accepted on that retiring edge.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   in   block offered          in_ready  out  sequencer idle
//   in_key     in   1024 key words k0..k15
//   in_tweak   in   128  t0=[63:0], t1=[127:64]
//   in_data    in   1024 plaintext
//   rd_in      out  1024 registered round-datapath input
//   rd_odd     out  0 = even round output selected, 1 = odd
//   rd_out     in   1024 selected round output, valid ROUND_LATENCY edges after rd_in changes
//   out_valid  out  result valid           out_ready in   consumer accepts
//   out_data   out  1024 ciphertext
//   busy       out  high whenever the FSM is not IDLE
module skein_threefish_sequencer
    import skein_pkg::*;
#(
    parameter int ROUND_LATENCY = 3,
    parameter int NUM_ITER      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_key,
    input  logic [127:0]  in_tweak,
    input  logic [1023:0] in_data,
    output logic [1023:0] rd_in,
    output logic          rd_odd,
    input  logic [1023:0] rd_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] out_data,
    output logic          busy
);

    localparam int SUBKEY_CNT = subkey_cnt(NUM_ITER);
    localparam int SW         = $clog2(SUBKEY_CNT);
    localparam int CW         = $clog2(ROUND_LATENCY + 1);

    localparam logic [SW-1:0] LAST_S  = SW'(2 * NUM_ITER);
    localparam logic [CW-1:0] CNT_CAP = CW'(ROUND_LATENCY);

    state_t        state;
    state_t        state_nxt;

    word_t         k_r [17];
    word_t         t_r [3];
    block_t        st;
    logic [SW-1:0] s;
    logic [1:0]    s_mod3;
    logic [4:0]    s_mod17;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          capture;
    logic          use_next;
    logic [SW-1:0] s_inc;
    logic [SW-1:0] ks_s;
    logic [1:0]    ks_mod3;
    logic [4:0]    ks_mod17;
    block_t        ks;
    word_t         key_parity;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = (state == ST_IDLE) && in_valid;
    assign s_inc    = s + SW'(1);

    // k16 is formed once at accept time from the raw key words.
    always_comb begin
        key_parity = C240;
        for (int i = 0; i < 16; i++) begin
            key_parity = key_parity ^ in_key[64*i +: 64];
        end
    end

    // The even-round capture injects K_{s+1}; LAUNCH and FINAL inject K_s.
    // rd_odd can still be 1 in LAUNCH (left over from the odd capture), so
    // the WAIT qualifier matters.
    assign use_next = (state == ST_WAIT) && !rd_odd;
    assign ks_s     = use_next ? s_inc : s;
    assign ks_mod3  = use_next ? inc_mod3(s_mod3) : s_mod3;
    assign ks_mod17 = use_next ? inc_mod17(s_mod17) : s_mod17;

    skein1024_subkey #(
        .SW (SW)
    ) u_subkey (
        .k       (k_r),
        .t       (t_r),
        .s       (ks_s),
        .s_mod3  (ks_mod3),
        .s_mod17 (ks_mod17),
        .ks      (ks)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // cnt reaches ROUND_LATENCY on the (ROUND_LATENCY+1)th edge
                // after rd_in was loaded, one edge after rd_out is valid.
                if (cnt == CNT_CAP) begin
                    capture = 1'b1;
                    if (rd_odd) begin
                        state_nxt = (s_inc == LAST_S) ? ST_FINAL : ST_LAUNCH;
                    end
                end
            end
            ST_FINAL: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 17; i++) begin
                k_r[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                t_r[i] <= '0;
            end
            st        <= '0;
            s         <= '0;
            s_mod3    <= '0;
            s_mod17   <= '0;
            cnt       <= '0;
            rd_in     <= '0;
            rd_odd    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 16; i++) begin
                            k_r[i] <= in_key[64*i +: 64];
                        end
                        k_r[16] <= key_parity;
                        t_r[0]  <= in_tweak[63:0];
                        t_r[1]  <= in_tweak[127:64];
                        t_r[2]  <= in_tweak[63:0] ^ in_tweak[127:64];
                        st      <= in_data;
                        s       <= '0;
                        s_mod3  <= '0;
                        s_mod17 <= '0;
                    end
                end
                ST_LAUNCH: begin
                    rd_in  <= add_words(st, ks);
                    rd_odd <= 1'b0;
                    cnt    <= '0;
                end
                ST_WAIT: begin
                    if (capture) begin
                        s       <= s_inc;
                        s_mod3  <= inc_mod3(s_mod3);
                        s_mod17 <= inc_mod17(s_mod17);
                        cnt     <= '0;
                        if (!rd_odd) begin
                            rd_in  <= add_words(rd_out, ks);
                            rd_odd <= 1'b1;
                        end else begin
                            st <= rd_out;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_FINAL: begin
                    out_data  <= add_words(st, ks);
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/skein_threefish_sequencer.md
Name: skein_threefish_sequencer

Overview:
- Sequences one Threefish-1024 block (the Skein-1024 UBI core) through the shared even/odd round datapath.
- Each iteration injects subkey, runs an even round, injects the next subkey, then runs an odd round.
- After NUM_ITER iterations it applies the final subkey and presents the result.
- Sits between the UBI chaining logic (upstream, valid/ready) and the two round datapaths. One block is in flight at a time.

Parameters:
- ROUND_LATENCY, 3, clock edges from round input to valid round output; must be ≥1.
- NUM_ITER, 10, number of even+odd iteration pairs; final subkey index is 2*NUM_ITER.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input block offered
- in_ready  out  1  sequencer idle; a block is accepted on an edge where in_valid && in_ready
- in_key  in  1024  key words k0..k15; word i is at bits [64i+63:64i]
- in_tweak  in  128  t0 = [63:0], t1 = [127:64]
- in_data  in  1024  plaintext block
- rd_in  out  1024  registered input to the round datapath
- rd_odd  out  1  0 selects the even round output, 1 selects the odd round output
- rd_out  in  1024  selected round output, valid ROUND_LATENCY edges after rd_in changes
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  1024  ciphertext
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, rd_in=0, rd_odd=0, out_data=0, out_valid=0, busy=0, s=0, cnt=0.
- in_ready = (state==IDLE). in_valid is ignored while rst is high.
- Reset asserted mid-operation: the block in flight is abandoned with no output. The first edge after release may accept a new block.
- Subkey K_s, all arithmetic mod 2^64:
  - word i = k[(s+i) mod 17]
  - word 13 += t[s mod 3]
  - word 14 += t[(s+1) mod 3]
  - word 15 += s
  - k16 = 0x1BD11BDAA9FC1A22 ^ k0 ^ … ^ k15; t2 = t0 ^ t1
  - s mod 3 and (s+1) mod 3 come from wrap counters, not dividers.
- State injection "x + K" is a wordwise 64-bit add of 16 words; carries never cross word boundaries.
- FSM states: IDLE, LAUNCH, WAIT, FINAL, DONE.
- IDLE: on accept, register k0..k16, t0..t2, st<=in_data, s<=0; go to LAUNCH.
- LAUNCH (1 edge): rd_in<=st+K_s, rd_odd<=0, cnt<=0; go to WAIT.
- WAIT: cnt increments each edge. The capture edge is the edge where cnt==ROUND_LATENCY, i.e. ROUND_LATENCY+1 edges after rd_in was loaded.
  - Capture with rd_odd=0: rd_in<=rd_out+K_{s+1}, rd_odd<=1, s<=s+1, cnt<=0; stay in WAIT.
  - Capture with rd_odd=1: st<=rd_out, s<=s+1; go to FINAL if s+1==2*NUM_ITER, else LAUNCH.
- FINAL (1 edge): out_data<=st+K_{2*NUM_ITER}, out_valid<=1; go to DONE.
- DONE: out_data and out_valid hold until out_ready is sampled high. On that edge out_valid<=0 and state goes to IDLE. No accept occurs on that same edge.
- Latency: out_valid rises NUM_ITER*(2*ROUND_LATENCY+3)+1 edges after the accept edge. With defaults that is 91 edges.
- rd_in and rd_odd are stable between launch and capture edges. The round datapath is never overlapped.

Decomposition:
- Package skein_pkg:
  - C240 constant 0x1BD11BDAA9FC1A22
  - 64-bit word and 1024-bit block typedefs
  - FSM state enum
  - SUBKEY_CNT = 2*NUM_ITER+1 helper
- Sub-module skein1024_subkey: combinational; inputs k0..k16, t0..t2, s, s mod 3; output K_s. The sequencer instantiates it once, indexed with s or s+1 as the state requires.

Test Plan:
- Subkey check: k_i=i, t0=1, t1=2, data=0 -> first LAUNCH rd_in words 0..12 = i, word13=14, word14=16, word15=15. Second injection word13=16, word14=18, word15=0x1BD11BDAA9FC1A23.
- Full block: key/tweak/data all zero, and an independent random vector, with the bench modelling the round datapath (ROUND_LATENCY=3) -> out_data matches the Threefish-1024 C model; out_valid rises exactly 91 edges after accept.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data/out_valid stable; in_ready=0 throughout; accepted the cycle out_ready=1, then in_ready=1 next cycle.
- Busy input: in_valid held high with changing in_data during processing -> no second accept; result corresponds to the first block only.
- Reset mid-op: assert rst 40 edges after accept -> out_valid=0, busy=0, in_ready=1 immediately. The next block completes correctly in 91 edges.
- Parameter sweep: ROUND_LATENCY=1 and 5 -> latency 51 and 131 edges respectively, with results matching the model.
